// File: rtl/proc_pkg.sv
// Shared constants for the processor control path: opcodes, sequencer states
// and instruction field positions used by the controller, bus mux and datapath.
package proc_pkg;

   localparam int DATA_W  = 16;
   localparam int NUM_REGS = 8;
   localparam int IR_W    = 9;

   localparam int OP_MSB = 8;
   localparam int OP_LSB = 6;
   localparam int RX_MSB = 5;
   localparam int RX_LSB = 3;
   localparam int RY_MSB = 2;
   localparam int RY_LSB = 0;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_t;

   function automatic logic [2:0] ir_op(input logic [IR_W-1:0] ir);
      return ir[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [2:0] ir_rx(input logic [IR_W-1:0] ir);
      return ir[RX_MSB:RX_LSB];
   endfunction

   function automatic logic [2:0] ir_ry(input logic [IR_W-1:0] ir);
      return ir[RY_MSB:RY_LSB];
   endfunction

   // add and sub are the only three-slot instructions
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit binary to one-hot-8 decoder with enable; drives the register load enables.
module dec3to8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] y
);

   always_comb begin
      y = 8'h00;
      if (en) begin
         y[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/proc_control_fsm.sv
// Instruction sequencer: captures a 9-bit instruction and steps T1..T3, driving
// bus-source selects and load enables. Outputs are flopped copies of the decode
// of the next state/ir, so each output is a pure function of the current state.
module proc_control_fsm
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [15:0] din,
   output logic [2:0]  rout,
   output logic        din_en,
   output logic        gout,
   output logic [7:0]  rin,
   output logic        ain,
   output logic        gin,
   output logic        addsub,
   output logic        done,
   output logic        busy
);

   state_t            state_q, state_d;
   logic [IR_W-1:0]   ir_q, ir_d;

   logic [2:0]        rout_q, rout_d;
   logic              din_en_q, din_en_d;
   logic              gout_q, gout_d;
   logic [7:0]        rin_q, rin_d;
   logic              ain_q, ain_d;
   logic              gin_q, gin_d;
   logic              addsub_q, addsub_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              rin_en_d;

   logic [2:0]        op_d, rx_d, ry_d;
   logic              unused_din;

   assign unused_din = ^din[15:9];

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               ir_d    = din[IR_W-1:0];
               state_d = S_T1;
            end
         end
         S_T1:    state_d = is_alu_op(ir_op(ir_q)) ? S_T2 : S_IDLE;
         S_T2:    state_d = S_T3;
         S_T3:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign op_d = ir_op(ir_d);
   assign rx_d = ir_rx(ir_d);
   assign ry_d = ir_ry(ir_d);

   // Decode what the outputs must be once state_d/ir_d become current.
   always_comb begin
      rout_d   = 3'd0;
      din_en_d = 1'b0;
      gout_d   = 1'b0;
      rin_en_d = 1'b0;
      ain_d    = 1'b0;
      gin_d    = 1'b0;
      addsub_d = 1'b0;
      done_d   = 1'b0;
      busy_d   = (state_d != S_IDLE);
      unique case (state_d)
         S_T1: begin
            unique case (op_d)
               OP_MV: begin
                  rout_d   = ry_d;
                  rin_en_d = 1'b1;
                  done_d   = 1'b1;
               end
               OP_MVI: begin
                  din_en_d = 1'b1;
                  rin_en_d = 1'b1;
                  done_d   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_d = rx_d;
                  ain_d  = 1'b1;
               end
               default: done_d = 1'b1;
            endcase
         end
         S_T2: begin
            rout_d   = ry_d;
            gin_d    = 1'b1;
            addsub_d = op_d[0];
         end
         S_T3: begin
            gout_d   = 1'b1;
            rin_en_d = 1'b1;
            done_d   = 1'b1;
         end
         default: ;
      endcase
   end

   dec3to8 u_rin_dec (
      .en  (rin_en_d),
      .sel (rx_d),
      .y   (rin_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ir_q     <= '0;
         rout_q   <= 3'd0;
         din_en_q <= 1'b0;
         gout_q   <= 1'b0;
         rin_q    <= 8'h00;
         ain_q    <= 1'b0;
         gin_q    <= 1'b0;
         addsub_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         rout_q   <= rout_d;
         din_en_q <= din_en_d;
         gout_q   <= gout_d;
         rin_q    <= rin_d;
         ain_q    <= ain_d;
         gin_q    <= gin_d;
         addsub_q <= addsub_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign rout   = rout_q;
   assign din_en = din_en_q;
   assign gout   = gout_q;
   assign rin    = rin_q;
   assign ain    = ain_q;
   assign gin    = gin_q;
   assign addsub = addsub_q;
   assign done   = done_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: directed and random instructions against a
// slot-by-slot model of the instruction set, plus a continuous invariant monitor.
module tb_proc_control_fsm;

   typedef struct packed {
      logic [2:0] rout;
      logic       din_en;
      logic       gout;
      logic [7:0] rin;
      logic       ain;
      logic       gin;
      logic       addsub;
      logic       done;
      logic       busy;
   } outs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [15:0] din;
   logic [2:0]  rout;
   logic        din_en, gout, ain, gin, addsub, done, busy;
   logic [7:0]  rin;
   outs_t       act;

   int checks = 0;
   int errors = 0;

   proc_control_fsm dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .din    (din),
      .rout   (rout),
      .din_en (din_en),
      .gout   (gout),
      .rin    (rin),
      .ain    (ain),
      .gin    (gin),
      .addsub (addsub),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   assign act = {rout, din_en, gout, rin, ain, gin, addsub, done, busy};

   // number of busy slots an instruction occupies
   function automatic int nslots(input logic [8:0] ins);
      int op;
      op = int'(ins[8:6]);
      return (op == 2 || op == 3) ? 3 : 1;
   endfunction

   // expected outputs in slot k (1-based) of instruction ins
   function automatic outs_t model(input logic [8:0] ins, input int k);
      outs_t o;
      int op, rx, ry;
      op = int'(ins[8:6]);
      rx = int'(ins[5:3]);
      ry = int'(ins[2:0]);
      o = '0;
      o.busy = 1'b1;
      if (op == 0) begin
         o.rout = 3'(ry);
         o.rin  = 8'(1 << rx);
         o.done = 1'b1;
      end else if (op == 1) begin
         o.din_en = 1'b1;
         o.rin    = 8'(1 << rx);
         o.done   = 1'b1;
      end else if (op == 2 || op == 3) begin
         if (k == 1) begin
            o.rout = 3'(rx);
            o.ain  = 1'b1;
         end else if (k == 2) begin
            o.rout   = 3'(ry);
            o.gin    = 1'b1;
            o.addsub = (op == 3);
         end else begin
            o.gout = 1'b1;
            o.rin  = 8'(1 << rx);
            o.done = 1'b1;
         end
      end else begin
         o.done = 1'b1;
      end
      return o;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ((din_en && gout) || ((rin & (rin - 8'd1)) != 8'h00)) begin
            errors++;
            $display("FAIL monitor: din_en=%0b gout=%0b rin=%02h (required exclusive selects, rin zero/one-hot)",
                     din_en, gout, rin);
         end
      end
   end

   // Entered and left at #1 after a rising edge with the DUT in IDLE.
   // mode: 0 = random run/din noise in slots, 1 = run held high.
   task automatic run_instr(input string name, input logic [8:0] ins, input int mode);
      int n;
      outs_t exp;
      din = {7'($urandom), ins};
      run = 1'b1;
      @(posedge clk); #1;
      n = nslots(ins);
      for (int k = 1; k <= n; k++) begin
         exp = model(ins, k);
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s slot T%0d: ins=%03h got=%05h required=%05h", name, k, ins, act, exp);
         end
         run = (mode == 1) ? 1'b1 : 1'($urandom);
         din = 16'($urandom);
         @(posedge clk); #1;
      end
      checks++;
      if (act !== outs_t'(0)) begin
         errors++;
         $display("FAIL %s idle: ins=%03h got=%05h required=00000", name, ins, act);
      end
      run = (mode == 1) ? 1'b1 : 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      run = 1'b1;
      din = 16'h0015;
      #3;
      checks++;
      if (act !== outs_t'(0)) begin
         errors++;
         $display("FAIL reset_initial: got=%05h required=00000", act);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (act !== outs_t'(0)) begin
         errors++;
         $display("FAIL reset_held_run: got=%05h required=00000", act);
      end
      run = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_instr("mv_r2_r5", 9'h015, 0);
      run_instr("mvi_r7", 9'h078, 0);
      checks++;
      if (din !== din) begin end
      run_instr("sub_r1_r6", 9'h0CE, 0);
      run_instr("mv_r3_r3", 9'h01B, 0);
      run_instr("nop_101", 9'h140, 0);
      run_instr("add_r0_r7", 9'h087, 0);
   endtask

   task automatic test_mvi_immediate();
      din = 16'h0078;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      din = 16'hBEEF;
      #1;
      if (act !== model(9'h078, 1)) begin
         errors++;
         $display("FAIL mvi_imm_T1: got=%05h required=%05h", act, model(9'h078, 1));
      end
      @(posedge clk); #1;
      checks++;
      if (act !== outs_t'(0)) begin
         errors++;
         $display("FAIL mvi_imm_idle: got=%05h required=00000", act);
      end
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_mv_r0_r1", 9'h001, 1);
      run_instr("b2b_add_r3_r4", 9'h09C, 1);
      run_instr("b2b_sub_r5_r5", 9'h0ED, 1);
      run = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_add();
      din = 16'h009C;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (act !== model(9'h09C, 2)) begin
         errors++;
         $display("FAIL mid_add_T2: got=%05h required=%05h", act, model(9'h09C, 2));
      end
      rst = 1'b1;
      #1;
      checks++;
      if (act !== outs_t'(0)) begin
         errors++;
         $display("FAIL mid_add_reset_immediate: got=%05h required=00000", act);
      end
      @(posedge clk); #1;
      checks++;
      if (act !== outs_t'(0)) begin
         errors++;
         $display("FAIL mid_add_reset_held: got=%05h required=00000", act);
      end
      run = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (act !== outs_t'(0)) begin
         errors++;
         $display("FAIL mid_add_after_release: got=%05h required=00000", act);
      end
      run_instr("post_reset_sub", 9'h0CE, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         run_instr("random", 9'($urandom), int'($urandom_range(0, 1)));
      end
      run = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mvi_immediate();
      test_back_to_back();
      test_reset_mid_add();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/proc_control_fsm.md
# proc_control_fsm

Control sequencer that drives the select side of the 16-bit processor bus mux (`mux10_16bit`) and the load side of everything that bus feeds. It captures a 9-bit instruction from `din`, then steps through time slots. In each slot it picks the bus source (`rout`/`din_en`/`gout`) and the destination load enables (`rin`, `ain`, `gin`), and it pulses `done` on the final slot. It sits between the external instruction/data source and the register file/ALU datapath.

## Interface
- No parameters; data width 16 and register count 8 are fixed.
- Clocking and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: start request, sampled in IDLE only.
- `din` in 16: instruction word; `din[8:0]` = opcode[8:6], rx[5:3], ry[2:0]; `din[15:9]` ignored.
- `rout` out 3: binary register select to bus mux.
- `din_en` out 1: bus source = `din`.
- `gout` out 1: bus source = G (`aluout`).
- `rin` out 8: one-hot register load enables r0..r7.
- `ain` out 1: load A from bus.
- `gin` out 1: load G from ALU.
- `addsub` out 1: 0 = add, 1 = subtract.
- `done` out 1: one-cycle pulse on the instruction's final slot.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, T1, T2, T3, using a 2-bit encoding.
- IDLE: if `run`=1, `ir <= din[8:0]` and go to T1. Otherwise stay. All outputs are 0.
- Opcodes:
  - 000 `mv rx,ry`: T1 drives `rout`=ry and `rin[rx]`=1 with `done`=1, then IDLE.
  - 001 `mvi rx,#d`: T1 drives `din_en`=1 and `rin[rx]`=1 with `done`=1, then IDLE. The immediate must be on `din` during T1.
  - 010 `add` / 011 `sub rx,ry`:
    - T1: `rout`=rx, `ain`=1.
    - T2: `rout`=ry, `gin`=1, `addsub`=opcode[0].
    - T3: `gout`=1, `rin[rx]`=1, `done`=1, then IDLE.
  - 100–111: NOP. T1 drives `done`=1 only, with no loads, then IDLE.
- Exclusivity: at most one of `din_en`/`gout` is high in any cycle. `rout` is 0 whenever it does not name the source. `rin` is all-zero or one-hot.
- `addsub` is 0 outside T2.
- `run` is ignored while `busy`=1; no queuing.
- `rx`=`ry` is legal. `mv r3,r3` asserts `rout`=3 and `rin`=0x08 in the same cycle.

## Timing
- All outputs are Moore outputs, decoded combinationally from state and registered `ir`. There is no path from `din` or `run` to any output.
- Latency from the `run` sample edge to `done`:
  - mv/mvi/NOP: `done` high in the next cycle (1 cycle).
  - add/sub: `done` in the 3rd cycle after capture.
- Back-to-back instructions: the state passes through IDLE for one cycle after `done`. With `run` held high, the next instruction is captured at that IDLE edge, so throughput is one IDLE cycle plus the slots.
- Reset values: state=IDLE, `ir`=0, and every output 0, including `rout`=0 and `rin`=0x00.
- Reset asserted mid-instruction immediately forces IDLE and zeroes all outputs. No partial `rin`/`gin` pulse survives. After release, the next `run` starts a fresh instruction.

## Structure
- Package `proc_pkg`: opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`), state encoding, and instruction field positions. The mux and datapath share these constants.
- Sub-module `dec3to8`: a 3-bit to one-hot-8 decoder with an enable, used for `rin`.
- Top level holds the state register, the `ir` register, and the output decode.

## Test plan
- Reset mid-add: assert `rst` during T2 -> all outputs 0 immediately; state is IDLE; the next `run` behaves normally.
- `mv r2,r5` (`din`=0x015): cycle after `run` -> `rout`=5, `rin`=0x04, `done`=1; then IDLE with all outputs 0.
- `mvi r7` (`din`=0x078), then immediate 0xBEEF on `din` -> T1 has `din_en`=1, `rin`=0x80, `done`=1, `gout`=0.
- `sub r1,r6` (`din`=0x0CE):
  - T1: `rout`=1, `ain`=1.
  - T2: `rout`=6, `gin`=1, `addsub`=1.
  - T3: `gout`=1, `rin`=0x02, `done`=1.
- `run` held high across `mv r0,r1` then `add r3,r4` -> exactly one IDLE cycle between; `run` pulses during T1–T3 are ignored.
- Opcode 101 -> `done` at T1 with `rin`=0, `ain`=`gin`=`din_en`=`gout`=0. A continuous checker flags any cycle with `din_en`&`gout` or non-one-hot `rin`.
